// File: rtl/noc_resp_scheduler.sv
// Response scheduler for the NoC command port: round-robin arbitration between
// read and write completions, serialized onto the 9-bit {ALE_WRITE, CMD_WRITE} link.
module noc_resp_scheduler #(
    parameter int         DATA_BYTES = 4,
    parameter logic [4:0] IDLE_FILL  = 5'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_hold,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [7:0]              rd_id,
    input  logic                    rd_err,
    input  logic [2:0]              rd_err_code,
    input  logic [DATA_BYTES*8-1:0] rd_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [7:0]              wr_id,
    input  logic                    wr_err,
    input  logic [2:0]              wr_err_code,
    output logic [7:0]              CMD_WRITE,
    output logic                    ALE_WRITE,
    output logic                    busy,
    output logic [15:0]             rd_pkt_cnt,
    output logic [15:0]             wr_pkt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_ID,
        S_DATA
    } state_t;

    localparam logic [8:0] IDLE_WORD = {1'b1, 3'b000, IDLE_FILL};
    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    state_t                    state_q, state_d;
    logic [8:0]                word_q, word_d;
    logic [2:0]                cnt_q, cnt_d;
    logic                      is_rd_q, is_rd_d;
    logic                      last_wr_q, last_wr_d;
    logic [7:0]                id_q, id_d;
    logic [DATA_BYTES*8-1:0]   data_q, data_d;
    logic [15:0]               rd_pkt_cnt_q, rd_pkt_cnt_d;
    logic [15:0]               wr_pkt_cnt_q, wr_pkt_cnt_d;
    logic                      final_word;
    logic                      window;
    logic                      grant_rd;
    logic                      grant_wr;

    function automatic logic [7:0] pick_byte(input logic [DATA_BYTES*8-1:0] data,
                                             input logic [2:0] idx);
        logic [DATA_BYTES*8-1:0] sh;
        sh = data >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    // The final word of a packet doubles as a grant slot so packets can abut.
    always_comb begin
        final_word = ((state_q == S_ID) && !is_rd_q) || ((state_q == S_DATA) && (cnt_q == 3'd0));
        window     = !rst && !tx_hold && ((state_q == S_IDLE) || final_word);
        grant_rd   = window && rd_valid && (!wr_valid || last_wr_q);
        grant_wr   = window && wr_valid && !grant_rd;
    end

    always_comb begin
        state_d      = state_q;
        word_d       = IDLE_WORD;
        cnt_d        = cnt_q;
        is_rd_d      = is_rd_q;
        last_wr_d    = last_wr_q;
        id_d         = id_q;
        data_d       = data_q;
        rd_pkt_cnt_d = rd_pkt_cnt_q;
        wr_pkt_cnt_d = wr_pkt_cnt_q;
        if (grant_rd) begin
            state_d      = S_HDR;
            word_d       = {1'b1, 3'b010, 1'b0, rd_err, rd_err_code};
            is_rd_d      = 1'b1;
            last_wr_d    = 1'b0;
            id_d         = rd_id;
            data_d       = rd_data;
            rd_pkt_cnt_d = rd_pkt_cnt_q + 16'd1;
        end else if (grant_wr) begin
            state_d      = S_HDR;
            word_d       = {1'b1, 3'b100, 1'b0, wr_err, wr_err_code};
            is_rd_d      = 1'b0;
            last_wr_d    = 1'b1;
            id_d         = wr_id;
            wr_pkt_cnt_d = wr_pkt_cnt_q + 16'd1;
        end else begin
            case (state_q)
                S_HDR: begin
                    state_d = S_ID;
                    word_d  = {1'b0, id_q};
                end
                S_ID: begin
                    if (is_rd_q) begin
                        state_d = S_DATA;
                        cnt_d   = LAST_BYTE;
                        word_d  = {1'b0, pick_byte(data_q, LAST_BYTE)};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 3'd1;
                        word_d = {1'b0, pick_byte(data_q, cnt_q - 3'd1)};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= IDLE_WORD;
            cnt_q        <= 3'd0;
            is_rd_q      <= 1'b0;
            last_wr_q    <= 1'b1;
            id_q         <= 8'd0;
            data_q       <= '0;
            rd_pkt_cnt_q <= 16'd0;
            wr_pkt_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            is_rd_q      <= is_rd_d;
            last_wr_q    <= last_wr_d;
            id_q         <= id_d;
            data_q       <= data_d;
            rd_pkt_cnt_q <= rd_pkt_cnt_d;
            wr_pkt_cnt_q <= wr_pkt_cnt_d;
        end
    end

    assign rd_ready               = grant_rd;
    assign wr_ready               = grant_wr;
    assign {ALE_WRITE, CMD_WRITE} = word_q;
    assign busy                   = (state_q != S_IDLE);
    assign rd_pkt_cnt             = rd_pkt_cnt_q;
    assign wr_pkt_cnt             = wr_pkt_cnt_q;

endmodule

// File: tb/tb_noc_resp_scheduler.sv
// Directed bench for noc_resp_scheduler: one task per scenario, inline checks.
module tb_noc_resp_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_hold = 1'b0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [7:0]  rd_id = 8'h00;
    logic        rd_err = 1'b0;
    logic [2:0]  rd_err_code = 3'b000;
    logic [31:0] rd_data = 32'h0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_id = 8'h00;
    logic        wr_err = 1'b0;
    logic [2:0]  wr_err_code = 3'b000;
    logic [7:0]  CMD_WRITE;
    logic        ALE_WRITE;
    logic        busy;
    logic [15:0] rd_pkt_cnt;
    logic [15:0] wr_pkt_cnt;
    logic [8:0]  link;

    int total_checks  = 0;
    int passed_checks = 0;

    noc_resp_scheduler #(.DATA_BYTES(4), .IDLE_FILL(5'h00)) dut (
        .clk(clk), .rst(rst), .tx_hold(tx_hold),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_err(rd_err),
        .rd_err_code(rd_err_code), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_err(wr_err),
        .wr_err_code(wr_err_code),
        .CMD_WRITE(CMD_WRITE), .ALE_WRITE(ALE_WRITE), .busy(busy),
        .rd_pkt_cnt(rd_pkt_cnt), .wr_pkt_cnt(wr_pkt_cnt)
    );

    assign link = {ALE_WRITE, CMD_WRITE};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        total_checks++;
        if (link !== 9'h100) $display("FAIL reset_link got=%h exp=%h", link, 9'h100);
        else passed_checks++;
        total_checks++;
        if ({busy, rd_ready, wr_ready} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=%b", {busy, rd_ready, wr_ready}, 3'b000);
        else passed_checks++;
        total_checks++;
        if ({rd_pkt_cnt, wr_pkt_cnt} !== 32'h0)
            $display("FAIL reset_cnt got=%h exp=%h", {rd_pkt_cnt, wr_pkt_cnt}, 32'h0);
        else passed_checks++;
    endtask

    task automatic test_single_read();
        logic [8:0] exp_w [7] = '{9'h140, 9'h03C, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, 9'h100};
        rd_valid = 1'b1;
        rd_id    = 8'h3C;
        rd_data  = 32'hDEADBEEF;
        #1;
        total_checks++;
        if ({rd_ready, wr_ready} !== 2'b10) $display("FAIL rd_grant got=%b exp=%b", {rd_ready, wr_ready}, 2'b10);
        else passed_checks++;
        tick();
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                total_checks++;
                if (rd_ready !== 1'b0) $display("FAIL rd_ready_one_cycle got=%b exp=0", rd_ready);
                else passed_checks++;
                rd_valid = 1'b0;
                rd_id    = 8'hFF;
                rd_data  = 32'h0;
            end
            total_checks++;
            if (link !== exp_w[i]) $display("FAIL rd_word%0d got=%h exp=%h", i, link, exp_w[i]);
            else passed_checks++;
            total_checks++;
            if (busy !== (i < 6)) $display("FAIL rd_busy%0d got=%b exp=%b", i, busy, (i < 6));
            else passed_checks++;
            tick();
        end
        total_checks++;
        if (rd_pkt_cnt !== 16'd1) $display("FAIL rd_cnt got=%0d exp=1", rd_pkt_cnt);
        else passed_checks++;
    endtask

    task automatic test_write_err();
        logic [8:0] exp_w [3] = '{9'h18D, 9'h007, 9'h100};
        wr_valid    = 1'b1;
        wr_id       = 8'h07;
        wr_err      = 1'b1;
        wr_err_code = 3'b101;
        #1;
        total_checks++;
        if ({rd_ready, wr_ready} !== 2'b01) $display("FAIL wr_grant got=%b exp=%b", {rd_ready, wr_ready}, 2'b01);
        else passed_checks++;
        tick();
        wr_valid    = 1'b0;
        wr_id       = 8'h00;
        wr_err      = 1'b0;
        wr_err_code = 3'b000;
        for (int i = 0; i < 3; i++) begin
            total_checks++;
            if (link !== exp_w[i]) $display("FAIL wr_word%0d got=%h exp=%h", i, link, exp_w[i]);
            else passed_checks++;
            tick();
        end
        total_checks++;
        if (wr_pkt_cnt !== 16'd1) $display("FAIL wr_cnt got=%0d exp=1", wr_pkt_cnt);
        else passed_checks++;
    endtask

    task automatic test_back_to_back();
        logic exp_r, exp_w;
        do_reset();
        rd_valid = 1'b1;
        wr_valid = 1'b1;
        rd_id    = 8'hA1;
        rd_data  = 32'h11223344;
        wr_id    = 8'hB2;
        #1;
        for (int c = 0; c <= 16; c++) begin
            exp_r = (c == 0) || (c == 8) || (c == 16);
            exp_w = (c == 6) || (c == 14);
            total_checks++;
            if ({rd_ready, wr_ready} !== {exp_r, exp_w})
                $display("FAIL b2b_ready_c%0d got=%b exp=%b", c, {rd_ready, wr_ready}, {exp_r, exp_w});
            else passed_checks++;
            if (c == 1 || c == 9) begin
                total_checks++;
                if (link !== 9'h140) $display("FAIL b2b_rhdr_c%0d got=%h exp=%h", c, link, 9'h140);
                else passed_checks++;
            end
            if (c == 7 || c == 15) begin
                total_checks++;
                if (link !== 9'h180) $display("FAIL b2b_whdr_c%0d got=%h exp=%h", c, link, 9'h180);
                else passed_checks++;
            end
            if (c == 8) begin
                total_checks++;
                if (link !== 9'h0B2) $display("FAIL b2b_wid got=%h exp=%h", link, 9'h0B2);
                else passed_checks++;
            end
            tick();
        end
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        total_checks++;
        if (link !== 9'h140) $display("FAIL b2b_last_hdr got=%h exp=%h", link, 9'h140);
        else passed_checks++;
        total_checks++;
        if ({rd_pkt_cnt, wr_pkt_cnt} !== {16'd3, 16'd2})
            $display("FAIL b2b_cnt got=%0d/%0d exp=3/2", rd_pkt_cnt, wr_pkt_cnt);
        else passed_checks++;
        repeat (6) tick();
        total_checks++;
        if ({busy, link} !== {1'b0, 9'h100}) $display("FAIL b2b_end got=%h exp=%h", {busy, link}, {1'b0, 9'h100});
        else passed_checks++;
    endtask

    task automatic test_tx_hold();
        logic [8:0] exp_d [4] = '{9'h001, 9'h002, 9'h003, 9'h004};
        rd_valid = 1'b1;
        rd_id    = 8'h11;
        rd_data  = 32'h01020304;
        #1;
        total_checks++;
        if (rd_ready !== 1'b1) $display("FAIL hold_rgrant got=%b exp=1", rd_ready);
        else passed_checks++;
        tick();
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_id    = 8'h22;
        tick();
        tx_hold = 1'b1;
        total_checks++;
        if (link !== 9'h011) $display("FAIL hold_id got=%h exp=%h", link, 9'h011);
        else passed_checks++;
        tick();
        for (int c = 3; c <= 9; c++) begin
            total_checks++;
            if (link !== ((c <= 6) ? exp_d[c-3] : 9'h100))
                $display("FAIL hold_word_c%0d got=%h exp=%h", c, link, ((c <= 6) ? exp_d[c-3] : 9'h100));
            else passed_checks++;
            total_checks++;
            if (wr_ready !== 1'b0) $display("FAIL hold_noready_c%0d got=%b exp=0", c, wr_ready);
            else passed_checks++;
            tick();
        end
        tx_hold = 1'b0;
        #1;
        total_checks++;
        if (wr_ready !== 1'b1) $display("FAIL hold_release_ready got=%b exp=1", wr_ready);
        else passed_checks++;
        tick();
        wr_valid = 1'b0;
        total_checks++;
        if (link !== 9'h180) $display("FAIL hold_whdr got=%h exp=%h", link, 9'h180);
        else passed_checks++;
        tick();
        tick();
        total_checks++;
        if (link !== 9'h100) $display("FAIL hold_end got=%h exp=%h", link, 9'h100);
        else passed_checks++;
    endtask

    task automatic test_drop();
        tx_hold  = 1'b1;
        rd_valid = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            total_checks++;
            if (rd_ready !== 1'b0) $display("FAIL drop_held_c%0d got=%b exp=0", c, rd_ready);
            else passed_checks++;
            tick();
        end
        rd_valid = 1'b0;
        tx_hold  = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total_checks++;
            if ({rd_ready, wr_ready, link} !== {2'b00, 9'h100})
                $display("FAIL drop_idle_c%0d got=%h exp=%h", c, {rd_ready, wr_ready, link}, {2'b00, 9'h100});
            else passed_checks++;
            tick();
        end
        total_checks++;
        if (rd_pkt_cnt !== 16'd4) $display("FAIL drop_cnt got=%0d exp=4", rd_pkt_cnt);
        else passed_checks++;
    endtask

    task automatic test_reset_mid();
        rd_valid = 1'b1;
        rd_id    = 8'h55;
        rd_data  = 32'hAABBCCDD;
        tick();
        rd_valid = 1'b0;
        repeat (4) tick();
        total_checks++;
        if (link !== 9'h0CC) $display("FAIL rstmid_byte3 got=%h exp=%h", link, 9'h0CC);
        else passed_checks++;
        rst = 1'b1;
        tick();
        rd_valid = 1'b1;
        #1;
        total_checks++;
        if ({rd_ready, busy, link} !== {2'b00, 9'h100})
            $display("FAIL rstmid_idle got=%h exp=%h", {rd_ready, busy, link}, {2'b00, 9'h100});
        else passed_checks++;
        total_checks++;
        if ({rd_pkt_cnt, wr_pkt_cnt} !== 32'h0)
            $display("FAIL rstmid_cnt got=%h exp=%h", {rd_pkt_cnt, wr_pkt_cnt}, 32'h0);
        else passed_checks++;
        tick();
        rst      = 1'b0;
        rd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total_checks++;
            if (link !== 9'h100) $display("FAIL rstmid_after_c%0d got=%h exp=%h", c, link, 9'h100);
            else passed_checks++;
            tick();
        end
    endtask

    task automatic test_counter_wrap();
        force dut.wr_pkt_cnt_q = 16'hFFFD;
        #1;
        release dut.wr_pkt_cnt_q;
        wr_valid = 1'b1;
        wr_id    = 8'h5A;
        #1;
        tick();
        total_checks++;
        if (wr_pkt_cnt !== 16'hFFFE) $display("FAIL wrap_fffe got=%h exp=%h", wr_pkt_cnt, 16'hFFFE);
        else passed_checks++;
        tick();
        total_checks++;
        if (wr_ready !== 1'b1) $display("FAIL wrap_b2b_ready got=%b exp=1", wr_ready);
        else passed_checks++;
        tick();
        total_checks++;
        if (wr_pkt_cnt !== 16'hFFFF) $display("FAIL wrap_ffff got=%h exp=%h", wr_pkt_cnt, 16'hFFFF);
        else passed_checks++;
        tick();
        tick();
        wr_valid = 1'b0;
        total_checks++;
        if (wr_pkt_cnt !== 16'h0000) $display("FAIL wrap_zero got=%h exp=%h", wr_pkt_cnt, 16'h0000);
        else passed_checks++;
        total_checks++;
        if (rd_pkt_cnt !== 16'h0000) $display("FAIL wrap_rd_untouched got=%h exp=%h", rd_pkt_cnt, 16'h0000);
        else passed_checks++;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_err();
        test_back_to_back();
        test_tx_hold();
        test_drop();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/noc_resp_scheduler.md
# noc_resp_scheduler

Response-side controller for the NoC command port. It accepts completed read and write transactions from two requesters, arbitrates between them round-robin, and serializes each response onto the 9-bit {ALE_WRITE, CMD_WRITE} link. It emits the idle word whenever no packet is in flight. It is the transmit counterpart of the command parser, which decodes READ/WRITE packets on {ALE_READ, CMD_READ}.

## Interface
Parameters:
- DATA_BYTES, 4: read-response payload bytes (1..8), sent MSB first.
- IDLE_FILL, 5'h00: low 5 bits of the idle word.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- tx_hold  in  1  blocks new grants; a packet already started always completes.
- rd_valid  in  1  read response pending.
- rd_ready  out  1  read descriptor accepted this cycle.
- rd_id  in  8  return ID.
- rd_err  in  1  error flag.
- rd_err_code  in  3  error code.
- rd_data  in  DATA_BYTES*8  read data.
- wr_valid  in  1  write response pending.
- wr_ready  out  1  write descriptor accepted this cycle.
- wr_id  in  8  return ID.
- wr_err  in  1  error flag.
- wr_err_code  in  3  error code.
- CMD_WRITE  out  8  link byte (registered).
- ALE_WRITE  out  1  link command flag (registered).
- busy  out  1  packet in flight.
- rd_pkt_cnt  out  16  read responses granted, wraps.
- wr_pkt_cnt  out  16  write responses granted, wraps.

## Operation
- Link word encoding: {ALE_WRITE, CMD_WRITE}.
  - Idle: {1, 3'b000, IDLE_FILL}.
  - Read header: {1, 3'b010, 1'b0, rd_err, rd_err_code}.
  - Write header: {1, 3'b100, 1'b0, wr_err, wr_err_code}.
  - Payload words have ALE=0.
- Read packet: header, ID byte, then DATA_BYTES data bytes from rd_data, MSB byte first. Length is DATA_BYTES+2 words.
- Write packet: header, then ID byte. Length is 2 words.
- FSM states and transitions:
  - IDLE → HDR on grant.
  - HDR → ID.
  - ID → DATA for a read; ID is the final word for a write.
  - DATA loops, with byte counter decrementing DATA_BYTES-1..0. Count 0 is the final word.
  - Final word → HDR on a new grant, otherwise → IDLE.
- Grant window: state is IDLE or the final word is being driven, and tx_hold=0, and at least one valid is high.
- Arbitration:
  - With a single requester valid, that requester is granted.
  - With both valid, the requester not granted last wins.
  - The last-grant pointer resets to "write", so read wins the first tie.
- rd_ready/wr_ready are combinational from state, valids, tx_hold and the pointer. At most one is high per cycle, for exactly one cycle per grant.
- On the grant edge:
  - The descriptor (id, err, code, data) is latched into internal registers, so the requester may change its inputs after that edge.
  - The matching pkt_cnt increments, wrapping 16'hFFFF → 0.
- busy = 1 in HDR, ID and DATA.

## Timing
- Grant in cycle N: header on outputs in N+1, ID in N+2, read data in N+3..N+2+DATA_BYTES.
- Back-to-back packets: a grant in the final-word cycle puts the next header in the very next cycle, with no idle gap.
- Reset values:
  - ALE_WRITE=1, CMD_WRITE={3'b000, IDLE_FILL}.
  - busy=0, rd_ready=wr_ready=0, both counters 0.
  - FSM in IDLE, pointer = write.
- rst mid-packet: the packet is abandoned and the idle word appears the cycle after rst is sampled. No ready is asserted while rst=1.
- tx_hold asserted mid-packet: the packet completes, then the idle word repeats until tx_hold=0.
- A valid that deasserts before its grant is dropped without a ready pulse.

## Test plan
- Single read: DATA_BYTES=4, rd_id=8'h3C, rd_data=32'hDEADBEEF, err=0. Expect rd_ready for 1 cycle, then words 9'h140, 9'h03C, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, then 9'h100; rd_pkt_cnt=1.
- Write with error: wr_id=8'h07, wr_err=1, wr_err_code=3'b101. Expect words 9'h18D, 9'h007, then idle; wr_pkt_cnt=1.
- Tie and back-to-back: rd_valid and wr_valid held high after reset. Expect read granted first, write header in the cycle right after the read's last byte, and further grants alternating R,W,R,W.
- tx_hold: assert tx_hold during a read's ID cycle with wr_valid=1. Expect the read to finish and idle words while held. Releasing tx_hold in cycle M gives wr_ready in M and the write header in M+1.
- Reset mid-packet: pulse rst during the third data byte. Expect 9'h100 the next cycle, counters 0, and no further payload words.
- Counter wrap: force 65536 write grants. Expect wr_pkt_cnt 16'hFFFF → 16'h0000.
